data_write_buffer: RTL and testbench
====================================

# data_write_buffer

Store buffer between the data-side sram-like output of the cache and the data port of the AXI interface. Uncached/write-through stores from the cache are accepted into a small FIFO and acknowledged in one cycle, then drained to the AXI interface in order. Reads are held until the buffer is empty, then passed straight through, so read-after-write ordering is preserved without address compare.

## Interface
- DEPTH, 4, entries in the store FIFO; power of two, ≥2
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- up_req  in  1  request from cache data side
- up_wr  in  1  1 = write, 0 = read
- up_size  in  2  0 byte, 1 half, 2 word
- up_addr  in  32  byte address
- up_wdata  in  32  store data
- up_rdata  out  32  load data (valid with up_data_ok on reads)
- up_addr_ok  out  1  request accepted this cycle
- up_data_ok  out  1  transaction complete
- down_req  out  1  request to AXI interface data port
- down_wr  out  1  write flag
- down_size  out  2  size
- down_addr  out  32  address
- down_wdata  out  32  write data
- down_rdata  in  32  read data
- down_addr_ok  in  1  downstream accepted request
- down_data_ok  in  1  downstream completed
- empty_o  out  1  FIFO empty and no downstream transaction in flight (used by flush/sync logic)

## Operation
- FIFO entry = {addr[31:0], size[1:0], wdata[31:0]}; count 0..DEPTH.
- Upstream write: up_addr_ok = up_req & up_wr & (count < DEPTH) & state≠RD_DATA; on handshake entry pushed, up_data_ok pulses next cycle.
- Upstream read: up_addr_ok = down_addr_ok only when state=IDLE, count=0; down_req = up_req & ~up_wr in that condition; on handshake -> RD_DATA.
- FSM: IDLE, WR_ADDR, WR_DATA, RD_DATA.
  - IDLE, count>0 -> WR_ADDR (drain has priority over upstream reads).
  - WR_ADDR: down_req=1, down_wr=1, head fields on down_*; on down_addr_ok -> WR_DATA.
  - WR_DATA: down_req=0; on down_data_ok pop head -> IDLE.
  - RD_DATA: up_data_ok = down_data_ok, up_rdata = down_rdata; on down_data_ok -> IDLE. No upstream request accepted.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Full (count=DEPTH): writes stall with up_addr_ok=0 until a pop; accepted the cycle after the pop.
- Pointers log2(DEPTH) bits, wrap naturally; count log2(DEPTH)+1 bits.
- Write-ack data_ok and read data_ok never coincide: a read is never accepted while count>0.
- Reset mid-operation: FIFO contents discarded, any downstream handshake abandoned, FSM to IDLE.

## Timing
- Reset values: up_data_ok 0, down_req 0, down_wr 0, down_size/addr/wdata 0, up_rdata 0, empty_o 1, count 0, state IDLE; up_addr_ok 0 while in reset.
- up_addr_ok, down_req, up_rdata, read up_data_ok are combinational; write up_data_ok is registered.
- Write ack latency: 1 cycle after accept. Drain: earliest down_req one cycle after push; minimum 2 cycles per entry (addr then data).
- down_* held stable from down_req assertion until down_addr_ok.
- empty_o = (count==0) & (state==IDLE).

## Structure
- Package data_wb_pkg: wb_state_t enum, wb_entry_t struct, size encodings.
- Sub-module wb_fifo (DEPTH-entry synchronous FIFO: push, pop, head, count, full, empty). FSM and muxing in data_write_buffer.

## Test plan
- Single store 0x1000/0xDEADBEEF, size 2, down_addr_ok and down_data_ok each after 2 cycles -> up_data_ok cycle+1; down_* shows entry; empty_o returns 1 after down_data_ok.
- Five back-to-back stores, DEPTH=4, downstream stalled -> first four acked, fifth up_addr_ok=0 until first pop, then accepted; downstream order 1..5.
- Store 0x2000=0x11 then load 0x2000 next cycle -> load stalls until store's down_data_ok; load issued after, returns down_rdata 0x11.
- Load with empty buffer, downstream data after 3 cycles 0xCAFEF00D -> up_data_ok and up_rdata pass through same cycle; store during RD_DATA not accepted.
- Push and pop same cycle with count=2 -> count stays 2; pointers wrap past DEPTH-1 correctly over 10 stores.
- aresetn low during WR_ADDR with count=3 -> all outputs to reset values, empty_o=1, no further down_req.

Source files
------------

// File: rtl/data_wb_pkg.sv
// data_wb_pkg
//   Shared types for the data-side store buffer.
//   - wb_state_t : drain/read sequencing state encoding
//   - wb_entry_t : one buffered store {addr, size, wdata}
//   - SIZE_*     : access size encodings carried on up_size/down_size
package data_wb_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef logic [1:0] wb_state_t;

    localparam wb_state_t ST_IDLE    = 2'd0;
    localparam wb_state_t ST_WR_ADDR = 2'd1;
    localparam wb_state_t ST_WR_DATA = 2'd2;
    localparam wb_state_t ST_RD_DATA = 2'd3;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
    } wb_entry_t;

endpackage

// File: rtl/data_write_buffer_fifo.sv
// wb_fifo
//   DEPTH-entry synchronous FIFO of buffered stores.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     push        : write push_entry at the tail (ignored when full)
//     push_entry  : entry to store
//     pop         : drop the head entry (ignored when empty)
//     head        : entry at the head of the queue
//     count       : number of valid entries, 0..DEPTH
//     full, empty : status flags derived from count
module wb_fifo
    import data_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  wb_entry_t                push_entry,
    input  logic                     pop,
    output wb_entry_t                head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    wb_entry_t         mem [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count_q == CntW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign count   = count_q;
    assign head    = mem[rd_ptr_q];

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing is read unless count says it is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_entry;
        end
    end

endmodule

// File: rtl/data_write_buffer.sv
// data_write_buffer
//   Store buffer between the cache data-side sram-like port and the AXI
//   interface data port. Stores are queued and acked one cycle after accept,
//   then drained in order (address phase, then data phase). Loads wait until
//   the queue is empty and idle, then pass straight through, which keeps
//   read-after-write ordering without address comparison.
//   Ports:
//     aclk, aresetn      : clock, asynchronous active-low reset
//     up_req/wr/size/addr/wdata, up_rdata, up_addr_ok, up_data_ok
//                        : sram-like port from the cache
//     down_req/wr/size/addr/wdata, down_rdata, down_addr_ok, down_data_ok
//                        : sram-like port to the AXI interface
//     empty_o            : queue empty and nothing in flight downstream
module data_write_buffer
    import data_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        aclk,
    input  logic        aresetn,

    input  logic        up_req,
    input  logic        up_wr,
    input  logic [1:0]  up_size,
    input  logic [31:0] up_addr,
    input  logic [31:0] up_wdata,
    output logic [31:0] up_rdata,
    output logic        up_addr_ok,
    output logic        up_data_ok,

    output logic        down_req,
    output logic        down_wr,
    output logic [1:0]  down_size,
    output logic [31:0] down_addr,
    output logic [31:0] down_wdata,
    input  logic [31:0] down_rdata,
    input  logic        down_addr_ok,
    input  logic        down_data_ok,

    output logic        empty_o
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    wb_state_t        state_q, state_d;
    logic             wr_ack_q;

    wb_entry_t        push_entry;
    wb_entry_t        head;
    logic [CntW-1:0]  fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;

    logic             wr_accept;
    logic             rd_pass;
    logic             in_idle;
    logic             in_wr_addr;
    logic             in_wr_data;
    logic             in_rd_data;

    assign in_idle    = (state_q == ST_IDLE);
    assign in_wr_addr = (state_q == ST_WR_ADDR);
    assign in_wr_data = (state_q == ST_WR_DATA);
    assign in_rd_data = (state_q == ST_RD_DATA);

    // Gated by aresetn so nothing handshakes combinationally during reset.
    assign wr_accept = aresetn & up_req & up_wr & ~fifo_full & ~in_rd_data;
    assign rd_pass   = aresetn & up_req & ~up_wr & in_idle & fifo_empty;

    assign push = wr_accept;
    assign pop  = in_wr_data & down_data_ok;

    always_comb begin
        push_entry       = '0;
        push_entry.addr  = up_addr;
        push_entry.size  = up_size;
        push_entry.wdata = up_wdata;
    end

    wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (aclk),
        .rst_n      (aresetn),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // Upstream side.
    assign up_addr_ok = wr_accept | (rd_pass & down_addr_ok);
    assign up_data_ok = wr_ack_q | (in_rd_data & down_data_ok);
    assign up_rdata   = in_rd_data ? down_rdata : 32'd0;

    // Downstream side: head entry while draining, the live load while passing.
    always_comb begin
        down_req   = 1'b0;
        down_wr    = 1'b0;
        down_size  = 2'd0;
        down_addr  = 32'd0;
        down_wdata = 32'd0;
        if (in_wr_addr) begin
            down_req   = 1'b1;
            down_wr    = 1'b1;
            down_size  = head.size;
            down_addr  = head.addr;
            down_wdata = head.wdata;
        end else if (rd_pass) begin
            down_req   = 1'b1;
            down_size  = up_size;
            down_addr  = up_addr;
        end
    end

    assign empty_o = (fifo_count == '0) & in_idle;

    // A push into an idle buffer heads straight to WR_ADDR so the entry is
    // offered downstream on the very next cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty || push) begin
                    state_d = ST_WR_ADDR;
                end else if (rd_pass && down_addr_ok) begin
                    state_d = ST_RD_DATA;
                end
            end
            ST_WR_ADDR: begin
                if (down_addr_ok) begin
                    state_d = ST_WR_DATA;
                end
            end
            ST_WR_DATA: begin
                if (down_data_ok) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_DATA: begin
                if (down_data_ok) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= ST_IDLE;
            wr_ack_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ack_q <= push;
        end
    end

endmodule

// File: tb/tb_data_write_buffer.sv
module tb_data_write_buffer;

    localparam int DEPTH = 4;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        up_req = 1'b0;
    logic        up_wr = 1'b0;
    logic [1:0]  up_size = 2'd0;
    logic [31:0] up_addr = 32'd0;
    logic [31:0] up_wdata = 32'd0;
    logic [31:0] up_rdata;
    logic        up_addr_ok;
    logic        up_data_ok;
    logic        down_req;
    logic        down_wr;
    logic [1:0]  down_size;
    logic [31:0] down_addr;
    logic [31:0] down_wdata;
    logic [31:0] down_rdata = 32'd0;
    logic        down_addr_ok = 1'b0;
    logic        down_data_ok = 1'b0;
    logic        empty_o;

    always #5 aclk = ~aclk;

    data_write_buffer #(
        .DEPTH(DEPTH)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .up_req       (up_req),
        .up_wr        (up_wr),
        .up_size      (up_size),
        .up_addr      (up_addr),
        .up_wdata     (up_wdata),
        .up_rdata     (up_rdata),
        .up_addr_ok   (up_addr_ok),
        .up_data_ok   (up_data_ok),
        .down_req     (down_req),
        .down_wr      (down_wr),
        .down_size    (down_size),
        .down_addr    (down_addr),
        .down_wdata   (down_wdata),
        .down_rdata   (down_rdata),
        .down_addr_ok (down_addr_ok),
        .down_data_ok (down_data_ok),
        .empty_o      (empty_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] data;
    } ent_t;

    ent_t q[$];         // stores accepted but not yet completed downstream
    bit   ack_pend;     // a store was accepted last cycle
    bit   rd_out;       // a load is in flight downstream
    bit   head_sent;    // head store's address phase done, awaiting data_ok
    bit   wait_stable;  // a store request was offered and not yet taken
    int   idle_cnt;

    always @(negedge aclk) begin
        if (!aresetn) begin
            chk("rst_up_addr_ok", {31'd0, up_addr_ok}, 32'd0);
            chk("rst_up_data_ok", {31'd0, up_data_ok}, 32'd0);
            chk("rst_down_req", {31'd0, down_req}, 32'd0);
            chk("rst_down_addr", down_addr, 32'd0);
            chk("rst_empty", {31'd0, empty_o}, 32'd1);
            q.delete();
            ack_pend = 0; rd_out = 0; head_sent = 0; wait_stable = 0; idle_cnt = 0;
        end else begin
            bit old_sent, old_rd;
            chk("up_data_ok", {31'd0, up_data_ok},
                {31'd0, ack_pend | (rd_out & down_data_ok)});
            if (rd_out && down_data_ok) chk("up_rdata", up_rdata, down_rdata);
            chk("empty_o", {31'd0, empty_o}, {31'd0, (q.size() == 0) && !rd_out});

            if (up_req && up_wr)
                chk("wr_addr_ok", {31'd0, up_addr_ok},
                    {31'd0, (q.size() < DEPTH) && !rd_out});
            if (up_req && !up_wr) begin
                if (q.size() == 0 && !rd_out) begin
                    chk("rd_down_req", {30'd0, down_req, down_wr}, 32'd2);
                    chk("rd_down_addr", down_addr, up_addr);
                    chk("rd_down_size", {30'd0, down_size}, {30'd0, up_size});
                    chk("rd_addr_ok", {31'd0, up_addr_ok}, {31'd0, down_addr_ok});
                end else begin
                    chk("rd_blocked", {31'd0, up_addr_ok}, 32'd0);
                end
            end
            if (!(up_req && !up_wr && q.size() == 0 && !rd_out))
                chk("no_stray_read", {31'd0, down_req & ~down_wr}, 32'd0);

            if (wait_stable) chk("wr_req_held", {30'd0, down_req, down_wr}, 32'd3);
            if (down_req && down_wr) begin
                chk("wr_has_entry", {31'd0, (q.size() > 0) && !head_sent}, 32'd1);
                if (q.size() > 0) begin
                    chk("wr_addr", down_addr, q[0].addr);
                    chk("wr_data", down_wdata, q[0].data);
                    chk("wr_size", {30'd0, down_size}, {30'd0, q[0].size});
                end
            end

            if (q.size() > 0 && !head_sent && !(down_req && down_wr)) idle_cnt++;
            else idle_cnt = 0;
            if (q.size() > 0 && !head_sent) chk("drain_progress", {31'd0, idle_cnt <= 1}, 32'd1);

            // advance model to the state after the coming edge
            old_sent = head_sent;
            old_rd   = rd_out;
            ack_pend = up_req && up_wr && up_addr_ok;
            if (ack_pend) q.push_back('{addr: up_addr, size: up_size, data: up_wdata});
            if (old_sent && down_data_ok) begin
                void'(q.pop_front());
                head_sent = 0;
            end
            if (down_req && down_wr && down_addr_ok) head_sent = 1;
            if (old_rd && down_data_ok) rd_out = 0;
            if (down_req && !down_wr && down_addr_ok) rd_out = 1;
            wait_stable = down_req && down_wr && !down_addr_ok;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic set_up(input bit req, input bit wr, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] data);
        up_req = req; up_wr = wr; up_size = size; up_addr = addr; up_wdata = data;
    endtask

    task automatic drain_one(input logic [31:0] addr, input logic [31:0] data);
        int n = 0;
        @(negedge aclk);
        while (!(down_req && down_wr) && n < 20) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 20) begin
            chk("drain_timeout", 32'd0, 32'd1);
            return;
        end
        chk("drain_addr", down_addr, addr);
        chk("drain_data", down_wdata, data);
        step(); down_addr_ok = 1'b1;
        step(); down_addr_ok = 1'b0;
        step(); down_data_ok = 1'b1;
        step(); down_data_ok = 1'b0;
    endtask

    task automatic do_reset();
        set_up(0, 0, 2'd0, 32'd0, 32'd0);
        down_addr_ok = 0; down_data_ok = 0; down_rdata = 0;
        aresetn = 1'b0;
        step(); step();
        aresetn = 1'b1;
    endtask

    initial begin
        bit      pend, up_hs, dn_hs, dn_done, slow;
        int      cnt;

        do_reset();
        step();

        // single store
        set_up(1, 1, 2'd2, 32'h1000, 32'hDEADBEEF);
        @(negedge aclk);
        chk("t1_accept", {31'd0, up_addr_ok}, 32'd1);
        chk("t1_empty_before", {31'd0, empty_o}, 32'd1);
        step(); set_up(0, 0, 2'd0, 32'd0, 32'd0);
        @(negedge aclk);
        chk("t1_ack", {31'd0, up_data_ok}, 32'd1);
        chk("t1_down_req", {30'd0, down_req, down_wr}, 32'd3);
        chk("t1_down_addr", down_addr, 32'h1000);
        chk("t1_down_wdata", down_wdata, 32'hDEADBEEF);
        chk("t1_down_size", {30'd0, down_size}, 32'd2);
        step(); step();
        step(); down_addr_ok = 1'b1;
        step(); down_addr_ok = 1'b0;
        @(negedge aclk);
        chk("t1_data_phase_req", {31'd0, down_req}, 32'd0);
        step(); step(); down_data_ok = 1'b1;
        @(negedge aclk);
        chk("t1_empty_busy", {31'd0, empty_o}, 32'd0);
        step(); down_data_ok = 1'b0;
        @(negedge aclk);
        chk("t1_empty_after", {31'd0, empty_o}, 32'd1);

        // five stores against a stalled downstream
        for (int i = 1; i <= 4; i++) begin
            step(); set_up(1, 1, 2'd2, 32'h100 * i, 32'h1111 * i);
            @(negedge aclk);
            chk("t2_accept", {31'd0, up_addr_ok}, 32'd1);
        end
        step(); set_up(1, 1, 2'd2, 32'h500, 32'h5555);
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            chk("t2_full_stall", {31'd0, up_addr_ok}, 32'd0);
            if (i < 2) step();
        end
        drain_one(32'h100, 32'h1111);
        @(negedge aclk);
        chk("t2_accept_after_pop", {31'd0, up_addr_ok}, 32'd1);
        step(); set_up(0, 0, 2'd0, 32'd0, 32'd0);
        for (int i = 2; i <= 5; i++) drain_one(32'h100 * i, 32'h1111 * i);

        // store then load of the same address
        step(); set_up(1, 1, 2'd0, 32'h2000, 32'h11);
        step(); set_up(1, 0, 2'd0, 32'h2000, 32'd0);
        @(negedge aclk);
        chk("t3_load_stall", {31'd0, up_addr_ok}, 32'd0);
        drain_one(32'h2000, 32'h11);
        @(negedge aclk);
        chk("t3_load_issued", {30'd0, down_req, down_wr}, 32'd2);
        chk("t3_load_addr", down_addr, 32'h2000);
        step(); down_addr_ok = 1'b1;
        @(negedge aclk);
        chk("t3_load_accept", {31'd0, up_addr_ok}, 32'd1);
        step(); set_up(0, 0, 2'd0, 32'd0, 32'd0);
        down_addr_ok = 1'b0; down_data_ok = 1'b1; down_rdata = 32'h11;
        @(negedge aclk);
        chk("t3_load_done", {31'd0, up_data_ok}, 32'd1);
        chk("t3_load_data", up_rdata, 32'h11);
        step(); down_data_ok = 1'b0; down_rdata = 32'd0;

        // load into an empty buffer; a store during the load waits
        step(); set_up(1, 0, 2'd2, 32'h3000, 32'd0); down_addr_ok = 1'b1;
        @(negedge aclk);
        chk("t4_load_accept", {31'd0, up_addr_ok}, 32'd1);
        step(); set_up(1, 1, 2'd2, 32'h3004, 32'h77); down_addr_ok = 1'b0;
        @(negedge aclk);
        chk("t4_store_blocked", {31'd0, up_addr_ok}, 32'd0);
        step(); step();
        down_data_ok = 1'b1; down_rdata = 32'hCAFEF00D;
        @(negedge aclk);
        chk("t4_data_ok", {31'd0, up_data_ok}, 32'd1);
        chk("t4_rdata", up_rdata, 32'hCAFEF00D);
        chk("t4_store_still_blocked", {31'd0, up_addr_ok}, 32'd0);
        step(); down_data_ok = 1'b0; down_rdata = 32'd0;
        @(negedge aclk);
        chk("t4_store_accept", {31'd0, up_addr_ok}, 32'd1);
        step(); set_up(0, 0, 2'd0, 32'd0, 32'd0);
        drain_one(32'h3004, 32'h77);

        // reset while draining with three entries queued
        for (int i = 0; i < 3; i++) begin
            step(); set_up(1, 1, 2'd2, 32'h4000 + 4 * i, i);
        end
        step(); set_up(1, 1, 2'd2, 32'h400C, 32'h3);
        @(negedge aclk);
        chk("t6_wr_addr", {30'd0, down_req, down_wr}, 32'd3);
        #2 aresetn = 1'b0;
        #1;
        chk("t6_rst_addr_ok", {31'd0, up_addr_ok}, 32'd0);
        chk("t6_rst_down_req", {30'd0, down_req, down_wr}, 32'd0);
        chk("t6_rst_down_addr", down_addr, 32'd0);
        chk("t6_rst_down_wdata", down_wdata, 32'd0);
        chk("t6_rst_empty", {31'd0, empty_o}, 32'd1);
        chk("t6_rst_data_ok", {31'd0, up_data_ok}, 32'd0);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            chk("t6_quiet_req", {31'd0, down_req}, 32'd0);
            chk("t6_quiet_empty", {31'd0, empty_o}, 32'd1);
            step();
        end

        // randomized traffic, checked by the model on every cycle
        pend = 0; cnt = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge aclk);
            up_hs   = up_req && up_addr_ok;
            dn_hs   = down_req && down_addr_ok;
            dn_done = down_data_ok;
            @(posedge aclk);
            #1;
            if (i == 2000) begin
                do_reset();
                pend = 0;
                continue;
            end
            slow = ((i / 400) % 2) == 1;
            if (up_hs) up_req = 1'b0;
            if (!up_req && i < 3800 && $urandom_range(0, 1) == 1) begin
                up_req   = 1'b1;
                up_wr    = ($urandom_range(0, 3) != 0);
                up_size  = 2'($urandom_range(0, 2));
                up_addr  = $urandom & 32'h0000_FFFC;
                up_wdata = $urandom;
            end
            if (dn_hs) begin
                pend = 1;
                cnt  = $urandom_range(0, 3);
            end
            if (dn_done) pend = 0;
            down_data_ok = 1'b0;
            down_rdata   = 32'd0;
            if (pend) begin
                down_addr_ok = 1'b0;
                if (cnt == 0) begin
                    down_data_ok = 1'b1;
                    down_rdata   = $urandom;
                end else begin
                    cnt--;
                end
            end else begin
                down_addr_ok = slow ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 2) != 0);
            end
        end
        set_up(0, 0, 2'd0, 32'd0, 32'd0);
        down_addr_ok = 1'b0; down_data_ok = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
